// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Main control FSM for a multi-cycle MIPS datapath. It sequences fetch,
//   decode, execute, memory and writeback for R-type, lw, sw, beq, j, addi
//   and jr. It talks to memory through a ready handshake and counts retired
//   instructions.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   opcode[5:0]            instr[31:26] from the instruction register
//   jrsignal               jr flag from the ALU controller (used in EXEC)
//   memready               memory finished the current read/write this cycle
//   pcwrite, pcwritecond   PC load (unconditional / qualified by ALU zero)
//   iord                   memory address select (0 = PC, 1 = ALUOut)
//   memread, memwrite      memory requests
//   irwrite                instruction register load
//   memtoreg, regdst       writeback data and destination selects
//   regwrite               register file write enable
//   alusrca, alusrcb[1:0]  ALU operand selects
//   aluop[1:0]             ALU controller op (00 funct, 01 add, 11 sub)
//   pcsource[1:0]          PC source (ALU, ALUOut, jump target, reg A)
//   illegal                one-cycle pulse on an unsupported opcode
//   state[3:0]             current state (debug)
//   retired[CNTW-1:0]      retired-instruction count, wraps
module multicycle_controller #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [5:0]      opcode,
    input  logic            jrsignal,
    input  logic            memready,
    output logic            pcwrite,
    output logic            pcwritecond,
    output logic            iord,
    output logic            memread,
    output logic            memwrite,
    output logic            irwrite,
    output logic            memtoreg,
    output logic            regdst,
    output logic            regwrite,
    output logic            alusrca,
    output logic [1:0]      alusrcb,
    output logic [1:0]      aluop,
    output logic [1:0]      pcsource,
    output logic            illegal,
    output logic [3:0]      state,
    output logic [CNTW-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JR     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t          state_reg, state_next;
    logic [CNTW-1:0] retired_reg;
    logic            retire_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= S_FETCH;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retire_next) begin
                retired_reg <= retired_reg + CNTW'(1);
            end
        end
    end

    // Next state and control decode. Everything is held at 0 while resetn
    // is low so an aborted instruction cannot leave a write strobe behind.
    always_comb begin
        state_next  = S_FETCH;
        retire_next = 1'b0;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop       = 2'b00;
        pcsource    = 2'b00;
        illegal     = 1'b0;
        if (resetn) begin
            case (state_reg)
                S_FETCH: begin
                    memread = 1'b1;
                    alusrcb = 2'b01;
                    aluop   = 2'b01;
                    // IR and PC+4 are captured only in the cycle memory answers
                    irwrite = memready;
                    pcwrite = memready;
                    state_next = memready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alusrcb = 2'b11;
                    aluop   = 2'b01;
                    case (opcode)
                        OP_RTYPE:     state_next = S_EXEC;
                        OP_LW, OP_SW: state_next = S_MEMADR;
                        OP_BEQ:       state_next = S_BEQ;
                        OP_J:         state_next = S_JUMP;
                        OP_ADDI:      state_next = S_ADDIEX;
                        default: begin
                            illegal    = 1'b1;
                            state_next = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    aluop   = 2'b01;
                    state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                    state_next = memready ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    memtoreg    = 1'b1;
                    regwrite    = 1'b1;
                    retire_next = 1'b1;
                end
                S_MEMWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                    state_next  = memready ? S_FETCH : S_MEMWR;
                    retire_next = memready;
                end
                S_EXEC: begin
                    alusrca = 1'b1;
                    state_next = jrsignal ? S_JR : S_RWB;
                end
                S_RWB: begin
                    regdst      = 1'b1;
                    regwrite    = 1'b1;
                    retire_next = 1'b1;
                end
                S_JR: begin
                    pcwrite     = 1'b1;
                    pcsource    = 2'b11;
                    retire_next = 1'b1;
                end
                S_BEQ: begin
                    alusrca     = 1'b1;
                    aluop       = 2'b11;
                    pcwritecond = 1'b1;
                    pcsource    = 2'b01;
                    retire_next = 1'b1;
                end
                S_JUMP: begin
                    pcwrite     = 1'b1;
                    pcsource    = 2'b10;
                    retire_next = 1'b1;
                end
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    aluop   = 2'b01;
                    state_next = S_ADDIWB;
                end
                S_ADDIWB: begin
                    regwrite    = 1'b1;
                    retire_next = 1'b1;
                end
                // Unused codes 13-15 recover to FETCH with all outputs low.
                default: state_next = S_FETCH;
            endcase
        end
    end

    assign state   = state_reg;
    assign retired = retired_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            resetn;
    logic [5:0]      opcode;
    logic            jrsignal;
    logic            memready;
    logic            pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic            memtoreg, regdst, regwrite, alusrca;
    logic [1:0]      alusrcb, aluop, pcsource;
    logic            illegal;
    logic [3:0]      state;
    logic [CNTW-1:0] retired;

    multicycle_controller #(.CNTW(CNTW)) dut (
        .clk(clk), .resetn(resetn), .opcode(opcode), .jrsignal(jrsignal),
        .memready(memready), .pcwrite(pcwrite), .pcwritecond(pcwritecond),
        .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
        .pcsource(pcsource), .illegal(illegal), .state(state),
        .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
        logic       memtoreg, regdst, regwrite, alusrca;
        logic [1:0] alusrcb, aluop, pcsource;
    } ctrl_t;

    typedef struct {
        logic [3:0] st;
        logic       mr;
        logic       jr;
    } step_t;

    ctrl_t dut_ctrl;
    assign dut_ctrl = '{pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                        memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsource};

    int compared   = 0;
    int mismatched = 0;
    int cnt_model  = 0;
    step_t path[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
               op == 6'h02 || op == 6'h08;
    endfunction

    // Expected control word for each state, taken from the state table.
    function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic mr);
        ctrl_t c = '0;
        case (st)
            4'd0:  begin c.memread = 1; c.alusrcb = 2'b01; c.aluop = 2'b01;
                         c.irwrite = mr; c.pcwrite = mr; end
            4'd1:  begin c.alusrcb = 2'b11; c.aluop = 2'b01; end
            4'd2:  begin c.alusrca = 1; c.alusrcb = 2'b10; c.aluop = 2'b01; end
            4'd3:  begin c.memread = 1; c.iord = 1; end
            4'd4:  begin c.memtoreg = 1; c.regwrite = 1; end
            4'd5:  begin c.memwrite = 1; c.iord = 1; end
            4'd6:  begin c.alusrca = 1; end
            4'd7:  begin c.regdst = 1; c.regwrite = 1; end
            4'd8:  begin c.alusrca = 1; c.aluop = 2'b11; c.pcwritecond = 1;
                         c.pcsource = 2'b01; end
            4'd9:  begin c.pcwrite = 1; c.pcsource = 2'b10; end
            4'd10: begin c.alusrca = 1; c.alusrcb = 2'b10; c.aluop = 2'b01; end
            4'd11: begin c.regwrite = 1; end
            4'd12: begin c.pcwrite = 1; c.pcsource = 2'b11; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected walk through the FSM for one instruction, with memready
    // supplied per cycle (random where it must be ignored).
    task automatic build(input logic [5:0] op, input logic jr, input int fw, input int mw);
        path.delete();
        for (int i = 0; i < fw; i++) path.push_back('{4'd0, 1'b0, rbit()});
        path.push_back('{4'd0, 1'b1, rbit()});
        path.push_back('{4'd1, rbit(), rbit()});
        case (op)
            6'h00: begin
                path.push_back('{4'd6, rbit(), jr});
                path.push_back('{jr ? 4'd12 : 4'd7, rbit(), rbit()});
            end
            6'h23: begin
                path.push_back('{4'd2, rbit(), rbit()});
                for (int i = 0; i < mw; i++) path.push_back('{4'd3, 1'b0, rbit()});
                path.push_back('{4'd3, 1'b1, rbit()});
                path.push_back('{4'd4, rbit(), rbit()});
            end
            6'h2B: begin
                path.push_back('{4'd2, rbit(), rbit()});
                for (int i = 0; i < mw; i++) path.push_back('{4'd5, 1'b0, rbit()});
                path.push_back('{4'd5, 1'b1, rbit()});
            end
            6'h04: path.push_back('{4'd8, rbit(), rbit()});
            6'h02: path.push_back('{4'd9, rbit(), rbit()});
            6'h08: begin
                path.push_back('{4'd10, rbit(), rbit()});
                path.push_back('{4'd11, rbit(), rbit()});
            end
            default: ;
        endcase
    endtask

    // Drives and checks each cycle of the built path. limit < 0 runs it all;
    // otherwise stops after 'limit' cycles (the instruction is left unfinished).
    task automatic run(input logic [5:0] op, input int limit);
        ctrl_t e;
        for (int i = 0; i < path.size(); i++) begin
            if (limit >= 0 && i >= limit) break;
            @(negedge clk);
            opcode   = op;
            memready = path[i].mr;
            jrsignal = path[i].jr;
            #1;
            e = exp_ctrl(path[i].st, path[i].mr);
            check("state", 32'(state), 32'(path[i].st));
            check("ctrl", 32'(dut_ctrl), 32'(e));
            check("illegal", 32'(illegal), 32'(path[i].st == 4'd1 && !is_legal(op)));
            check("retired", 32'(retired), 32'(cnt_model));
        end
        if (limit < 0 && is_legal(op)) cnt_model = (cnt_model + 1) % (1 << CNTW);
        $display("instr op=%02h cycles=%0d retired_model=%0d", op, path.size(), cnt_model);
    endtask

    task automatic instr(input logic [5:0] op, input logic jr, input int fw, input int mw);
        build(op, jr, fw, mw);
        run(op, -1);
    endtask

    // Assert reset mid-cycle, check outputs collapse at once, release just
    // after a rising edge so the next sampled cycle is the first fetch.
    task automatic do_reset();
        resetn = 1'b0;
        memready = 1'b1;
        #1;
        check("rst_ctrl", 32'(dut_ctrl), 32'(0));
        check("rst_illegal", 32'(illegal), 32'(0));
        check("rst_state", 32'(state), 32'(0));
        check("rst_retired", 32'(retired), 32'(0));
        cnt_model = 0;
        @(posedge clk);
        @(posedge clk);
        #2 resetn = 1'b1;
        $display("reset applied");
    endtask

    initial begin
        logic [5:0] legal_ops[6];
        logic [5:0] op;
        legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
        resetn = 1'b0; memready = 1'b1; opcode = 6'h00; jrsignal = 1'b0;
        #1;
        do_reset();

        instr(6'h00, 1'b0, 0, 0);   // add: 0,1,6,7
        instr(6'h23, 1'b0, 3, 2);   // lw with waits: 10 cycles
        instr(6'h04, 1'b0, 0, 0);   // beq: 0,1,8
        instr(6'h00, 1'b1, 0, 0);   // jr: 0,1,6,12
        instr(6'h3F, 1'b0, 0, 0);   // illegal: 0,1
        instr(6'h2B, 1'b0, 1, 3);   // sw with waits
        instr(6'h08, 1'b0, 0, 1);   // addi

        // sw aborted by reset while waiting in MEMWR
        build(6'h2B, 1'b0, 0, 3);
        run(6'h2B, 4);
        check("abort_in_memwr", 32'(state), 32'(5));
        do_reset();

        // counter wrap: 16 jumps take retired 15 -> 0
        for (int k = 0; k < 16; k++) instr(6'h02, 1'b0, 0, 0);
        instr(6'h02, 1'b0, 0, 0);

        // random mix against the model
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom); while (is_legal(op));
            end else begin
                op = legal_ops[$urandom_range(0, 5)];
            end
            instr(op, rbit(), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
